// File: rtl/mod_counter_ud.sv
// Modulo-UPTO up/down counter with parallel load, wrap or saturate at the
// boundaries, a combinational terminal-count output for cascading and a registered boundary pulse.
module mod_counter_ud #(
    parameter int NBITS    = 4,
    parameter int UPTO     = 11,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [NBITS-1:0] din,
    output logic [NBITS-1:0] q,
    output logic [NBITS-1:0] qbar,
    output logic             tc,
    output logic             evt
);

    // The modulus must leave at least two states and fit in NBITS.
    if ((UPTO < 2) || (64'(UPTO) > (64'd1 << NBITS))) begin : g_bad_param
        $error("mod_counter_ud: UPTO=%0d illegal for NBITS=%0d", UPTO, NBITS);
    end

    localparam logic [NBITS-1:0] MAX_CNT = NBITS'(UPTO - 1);

    logic [NBITS-1:0] q_q, q_d;
    logic             evt_q, evt_d;
    logic             at_top, at_bot;

    assign at_top = (q_q == MAX_CNT);
    assign at_bot = (q_q == '0);

    // Boundaries are decoded explicitly so UPTO == 2**NBITS never relies on overflow.
    always_comb begin
        q_d   = q_q;
        evt_d = 1'b0;
        if (load) begin
            q_d = (din > MAX_CNT) ? MAX_CNT : din;
        end else if (en) begin
            if (up) begin
                if (at_top) begin
                    evt_d = 1'b1;
                    q_d   = SATURATE ? q_q : '0;
                end else begin
                    q_d = q_q + NBITS'(1);
                end
            end else begin
                if (at_bot) begin
                    evt_d = 1'b1;
                    q_d   = SATURATE ? q_q : MAX_CNT;
                end else begin
                    q_d = q_q - NBITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q_q   <= '0;
            evt_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            evt_q <= evt_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;
    assign evt  = evt_q;
    assign tc   = en & ~load & ((up & at_top) | (~up & at_bot));

endmodule

// File: tb/tb_mod_counter_ud.sv
// Directed bench for mod_counter_ud: wrap (4-bit/11), saturate (4-bit/11)
// and full-range (3-bit/8) instances share the control inputs.
module tb_mod_counter_ud;

    logic       clk = 1'b0;
    logic       clear, en, up, load;
    logic [3:0] din4;
    logic [2:0] din3;

    logic [3:0] q_w, qbar_w, q_s, qbar_s;
    logic [2:0] q_f, qbar_f;
    logic       tc_w, evt_w, tc_s, evt_s, tc_f, evt_f;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mod_counter_ud #(.NBITS(4), .UPTO(11), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .din(din4),
        .q(q_w), .qbar(qbar_w), .tc(tc_w), .evt(evt_w)
    );

    mod_counter_ud #(.NBITS(4), .UPTO(11), .SATURATE(1'b1)) u_sat (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .din(din4),
        .q(q_s), .qbar(qbar_s), .tc(tc_s), .evt(evt_s)
    );

    mod_counter_ud #(.NBITS(3), .UPTO(8), .SATURATE(1'b0)) u_full (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .din(din3),
        .q(q_f), .qbar(qbar_f), .tc(tc_f), .evt(evt_f)
    );

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Short clear pulse placed between edges.
    task automatic do_clear();
        en    = 1'b0;
        load  = 1'b0;
        clear = 1'b1;
        #2;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; din4 = '0; din3 = '0;
        #2;
        checks++;
        if (q_w !== 4'd0 || qbar_w !== 4'hF || evt_w !== 1'b0) begin
            failures++;
            $display("FAIL reset_wrap q=%0d qbar=%h evt=%b required q=0 qbar=f evt=0", q_w, qbar_w, evt_w);
        end
        checks++;
        if (q_s !== 4'd0 || qbar_s !== 4'hF || q_f !== 3'd0 || qbar_f !== 3'h7) begin
            failures++;
            $display("FAIL reset_other q_s=%0d qbar_s=%h q_f=%0d qbar_f=%h required 0 f 0 7", q_s, qbar_s, q_f, qbar_f);
        end
        up = 1'b0; en = 1'b1;
        #1;
        checks++;
        if (tc_w !== 1'b1) begin
            failures++;
            $display("FAIL reset_tc_down tc=%b required 1", tc_w);
        end
        en = 1'b0;
        step();
        clear = 1'b0;
        step();
        checks++;
        if (evt_w !== 1'b0 || q_w !== 4'd0) begin
            failures++;
            $display("FAIL clear_release evt=%b q=%0d required evt=0 q=0", evt_w, q_w);
        end
    endtask

    task automatic test_up_wrap();
        logic [3:0] exp_q;
        logic [3:0] prev_q;
        do_clear();
        en = 1'b1; up = 1'b1;
        prev_q = 4'd0;
        for (int i = 1; i <= 12; i++) begin
            #1;
            checks++;
            if (tc_w !== (prev_q == 4'd10)) begin
                failures++;
                $display("FAIL up_wrap_tc edge=%0d tc=%b required %b", i, tc_w, (prev_q == 4'd10));
            end
            step();
            exp_q = (i <= 10) ? 4'(i) : 4'(i - 11);
            checks++;
            if (q_w !== exp_q || evt_w !== (i == 11) || qbar_w !== ~exp_q) begin
                failures++;
                $display("FAIL up_wrap edge=%0d q=%0d evt=%b qbar=%h required q=%0d evt=%b", i, q_w, evt_w, qbar_w, exp_q, (i == 11));
            end
            prev_q = exp_q;
        end
    endtask

    task automatic test_down_wrap();
        do_clear();
        en = 1'b1; up = 1'b0;
        step();
        checks++;
        if (q_w !== 4'd10 || evt_w !== 1'b1) begin
            failures++;
            $display("FAIL down_wrap_1 q=%0d evt=%b required q=10 evt=1", q_w, evt_w);
        end
        step();
        checks++;
        if (q_w !== 4'd9 || evt_w !== 1'b0) begin
            failures++;
            $display("FAIL down_wrap_2 q=%0d evt=%b required q=9 evt=0", q_w, evt_w);
        end
    endtask

    task automatic test_saturate();
        do_clear();
        load = 1'b1; din4 = 4'd10;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (q_s !== 4'd10 || evt_s !== 1'b1) begin
                failures++;
                $display("FAIL sat_hold edge=%0d q=%0d evt=%b required q=10 evt=1", i, q_s, evt_s);
            end
        end
        up = 1'b0;
        step();
        checks++;
        if (q_s !== 4'd9 || evt_s !== 1'b0) begin
            failures++;
            $display("FAIL sat_down q=%0d evt=%b required q=9 evt=0", q_s, evt_s);
        end
        do_clear();
        en = 1'b1; up = 1'b0;
        step();
        checks++;
        if (q_s !== 4'd0 || evt_s !== 1'b1) begin
            failures++;
            $display("FAIL sat_bottom q=%0d evt=%b required q=0 evt=1", q_s, evt_s);
        end
    endtask

    task automatic test_load();
        do_clear();
        load = 1'b1; din4 = 4'd7; en = 1'b1; up = 1'b0;
        #1;
        checks++;
        if (tc_w !== 1'b0) begin
            failures++;
            $display("FAIL load_tc_bottom tc=%b required 0", tc_w);
        end
        step();
        checks++;
        if (q_w !== 4'd7 || evt_w !== 1'b0) begin
            failures++;
            $display("FAIL load_7 q=%0d evt=%b required q=7 evt=0", q_w, evt_w);
        end
        din4 = 4'd14;
        step();
        checks++;
        if (q_w !== 4'd10) begin
            failures++;
            $display("FAIL load_clamp q=%0d required 10", q_w);
        end
        din4 = 4'd3; en = 1'b1; up = 1'b1;
        #1;
        checks++;
        if (tc_w !== 1'b0) begin
            failures++;
            $display("FAIL load_tc_top tc=%b required 0", tc_w);
        end
        en = 1'b0;
        step();
        checks++;
        if (q_w !== 4'd3 || evt_w !== 1'b0) begin
            failures++;
            $display("FAIL load_3 q=%0d evt=%b required q=3 evt=0", q_w, evt_w);
        end
        load = 1'b0;
    endtask

    task automatic test_async_clear();
        do_clear();
        load = 1'b1; din4 = 4'd5;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        checks++;
        if (q_w !== 4'd6) begin
            failures++;
            $display("FAIL pre_clear q=%0d required 6", q_w);
        end
        #3;
        clear = 1'b1;
        #1;
        checks++;
        if (q_w !== 4'd0 || qbar_w !== 4'hF || evt_w !== 1'b0) begin
            failures++;
            $display("FAIL async_clear q=%0d qbar=%h evt=%b required q=0 qbar=f evt=0", q_w, qbar_w, evt_w);
        end
        #1;
        clear = 1'b0;
        step();
        checks++;
        if (q_w !== 4'd1 || evt_w !== 1'b0) begin
            failures++;
            $display("FAIL after_clear q=%0d evt=%b required q=1 evt=0", q_w, evt_w);
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        load = 1'b1; din4 = 4'd5;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        up = 1'b0;
        step();
        checks++;
        if (q_w !== 4'd5) begin
            failures++;
            $display("FAIL toggle_down q=%0d required 5", q_w);
        end
        up = 1'b1;
        step();
        checks++;
        if (q_w !== 4'd6) begin
            failures++;
            $display("FAIL toggle_up q=%0d required 6", q_w);
        end
        en = 1'b0;
        step();
        checks++;
        if (q_w !== 4'd6 || evt_w !== 1'b0) begin
            failures++;
            $display("FAIL hold q=%0d evt=%b required q=6 evt=0", q_w, evt_w);
        end
    endtask

    task automatic test_full_range();
        logic [2:0] exp_q;
        do_clear();
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            exp_q = 3'(i % 8);
            checks++;
            if (q_f !== exp_q || qbar_f !== ~exp_q || evt_f !== (i == 8)) begin
                failures++;
                $display("FAIL full_range edge=%0d q=%0d qbar=%h evt=%b required q=%0d evt=%b", i, q_f, qbar_f, evt_f, exp_q, (i == 8));
            end
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_load();
        test_async_clear();
        test_back_to_back();
        test_full_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mod_counter_ud.md
MOD_COUNTER_UD -- requirements
Module: mod_counter_ud

Interface
REQ-001 Parameter NBITS, default 4: counter width in bits.
REQ-002 Parameter UPTO, default 11: modulus; legal count range is 0..UPTO-1.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at the boundary, 1 = hold at the boundary.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port clear, input, 1: reset; asynchronous and active-high.
REQ-006 Port en, input, 1: count enable.
REQ-007 Port up, input, 1: direction; 1 = increment, 0 = decrement.
REQ-008 Port load, input, 1: synchronous parallel-load strobe.
REQ-009 Port din, input, NBITS: parallel-load value.
REQ-010 Port q, output, NBITS: current count, registered.
REQ-011 Port qbar, output, NBITS: bitwise complement of q.
REQ-012 Port tc, output, 1: terminal count, combinational, for cascading.
REQ-013 Port evt, output, 1: registered one-cycle boundary-event pulse.

Function
REQ-014 Parameter legality: 2 <= UPTO <= 2**NBITS; elaboration shall fail for any other value.
REQ-015 Priority per rising clock edge: load > en > hold.
- clear overrides all of these asynchronously.
REQ-016 load=1: q <= din if din < UPTO, else q <= UPTO-1 (clamp); evt <= 0.
- The up and en inputs are ignored during a load.
REQ-017 en=1, up=1, q < UPTO-1: q <= q+1; evt <= 0.
REQ-018 en=1, up=1, q == UPTO-1:
- SATURATE=0: q <= 0; evt <= 1.
- SATURATE=1: q holds; evt <= 1.
REQ-019 en=1, up=0, q > 0: q <= q-1; evt <= 0.
REQ-020 en=1, up=0, q == 0:
- SATURATE=0: q <= UPTO-1; evt <= 1.
- SATURATE=1: q holds at 0; evt <= 1.
REQ-021 en=0 and load=0: q holds; evt <= 0.
- evt is therefore never high for two consecutive cycles unless a boundary event repeats.
REQ-022 tc = en & ~load & ((up & q==UPTO-1) | (~up & q==0)), combinational with no registering.
- In wrap mode, cascaded stages use tc as their en.
REQ-023 qbar shall always equal ~q, including during and after clear.
REQ-024 All comparisons and next-count arithmetic are NBITS wide.
- q never takes a value >= UPTO.
- When UPTO = 2**NBITS, wrap shall still follow REQ-018 and REQ-020 and shall not depend on natural overflow.
REQ-025 Toggling up between cycles takes effect on the next edge, with no dead cycle.

Reset
REQ-026 While clear=1, the outputs shall be q=0, qbar=all ones and evt=0, asynchronously and without waiting for clk.
- tc follows REQ-022 with q=0.
REQ-027 clear asserted mid-count or mid-load discards the operation in progress.
- The first edge after clear deasserts evaluates normally from q=0.
REQ-028 clear deassertion shall not by itself produce an evt pulse.

Verification (NBITS=4, UPTO=11 unless stated)
REQ-029 Up-count wrap: clear; then en=1, up=1 for 12 edges.
- Required: q=1..10, then 0, then 1.
- evt=1 only in the cycle q returns to 0.
- tc=1 while q=10.
REQ-030 Down-count wrap: from q=0, en=1, up=0 for 2 edges.
- Required: q=10 with evt=1, then q=9 with evt=0.
REQ-031 Saturate mode (SATURATE=1): from q=10, en=1, up=1 for 3 edges.
- Required: q stays 10 and evt=1 on each edge.
- Then up=0 for 1 edge: q=9, evt=0.
REQ-032 Load clamp and priority:
- load=1, din=7, en=1, up=0: q=7.
- load=1, din=14: q=10.
- load=1, din=3, en=0: q=3.
- tc=0 whenever load=1.
REQ-033 Async clear: assert clear between edges while q=6.
- Required: q=0 and qbar=4'b1111 before the next edge; evt=0.
- First edge after release with en=1, up=1: q=1.
REQ-034 Full range (NBITS=3, UPTO=8): 9 up-count edges from 0.
- Required: q=1..7, then 0 with evt=1.
- qbar equals ~q throughout.
